// File: rtl/ast_rr_mux_pkg.sv
// Shared widths, FSM state and beat layout for the Avalon-ST round-robin mux.
package ast_rr_mux_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8);
    localparam int CHANNEL_WIDTH = 10;
    localparam int RX_DIR        = 4;
    localparam int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_e;

    typedef logic [DIR_SEL_WIDTH-1:0] dir_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    data;
        logic                     sop;
        logic                     eop;
        logic [EMPTY_WIDTH-1:0]   empty;
        logic [CHANNEL_WIDTH-1:0] channel;
        dir_t                     dir;
    } beat_t;

    // Explicit wrap so non-power-of-two RX_DIR never indexes past the last input.
    function automatic dir_t next_dir(input dir_t d);
        if (int'(d) == RX_DIR - 1) return '0;
        return d + 1'b1;
    endfunction

endpackage

// File: rtl/ast_rr_mux_if.sv
// Avalon-ST bundle: RX_DIR sink ports plus one source port and the drop pulse.
interface ast_rr_mux_if;
    import ast_rr_mux_pkg::*;

    logic [DATA_WIDTH-1:0]    ast_data_i [RX_DIR];
    logic [RX_DIR-1:0]        ast_startofpacket_i;
    logic [RX_DIR-1:0]        ast_endofpacket_i;
    logic [RX_DIR-1:0]        ast_valid_i;
    logic [EMPTY_WIDTH-1:0]   ast_empty_i [RX_DIR];
    logic [CHANNEL_WIDTH-1:0] ast_channel_i [RX_DIR];
    logic [RX_DIR-1:0]        ast_ready_o;

    logic [DATA_WIDTH-1:0]    ast_data_o;
    logic                     ast_startofpacket_o;
    logic                     ast_endofpacket_o;
    logic                     ast_valid_o;
    logic [EMPTY_WIDTH-1:0]   ast_empty_o;
    logic [CHANNEL_WIDTH-1:0] ast_channel_o;
    logic [DIR_SEL_WIDTH-1:0] ast_dir_o;
    logic                     ast_ready_i;
    logic                     drop_o;

    modport slave (
        input  ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
               ast_empty_i, ast_channel_i, ast_ready_i,
        output ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
               ast_valid_o, ast_empty_o, ast_channel_o, ast_dir_o, drop_o
    );

    modport master (
        output ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
               ast_empty_i, ast_channel_i, ast_ready_i,
        input  ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
               ast_valid_o, ast_empty_o, ast_channel_o, ast_dir_o, drop_o
    );

endinterface

// File: rtl/ast_rr_arbiter.sv
// Combinational circular priority encoder: first set req at or after ptr wins.
module ast_rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N == 1) ? 1 : $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] grant_o,
    output logic         any_req_o
);

    int idx;

    // Scan farthest-first so the candidate closest to ptr overwrites the rest.
    always_comb begin
        grant_o   = '0;
        any_req_o = 1'b0;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % N;
            if (req_i[idx]) begin
                grant_o   = W'(idx);
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ast_rr_mux.sv
// Packet-level round-robin merge of RX_DIR Avalon-ST inputs into one registered output.
module ast_rr_mux
    import ast_rr_mux_pkg::*;
(
    input  logic         clk_i,
    input  logic         arst_n_i,
    ast_rr_mux_if.slave  ast
);

    state_e            state_q, state_d;
    dir_t              grant_q, grant_d;
    dir_t              ptr_q, ptr_d;
    beat_t             out_q, out_d;
    logic              vld_q, vld_d;

    logic              accept, xfer, drop_c;
    logic [RX_DIR-1:0] req, drop_rdy, rdy;
    dir_t              win;
    logic              any_req;

    assign accept   = !vld_q || ast.ast_ready_i;
    assign req      = ast.ast_valid_i & ast.ast_startofpacket_i;
    assign drop_rdy = ast.ast_valid_i & ~ast.ast_startofpacket_i;

    ast_rr_arbiter #(.N(RX_DIR), .W(DIR_SEL_WIDTH)) u_arb (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .grant_o   (win),
        .any_req_o (any_req)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        rdy     = '0;
        drop_c  = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                rdy    = drop_rdy;
                drop_c = |drop_rdy;
                if (any_req) begin
                    grant_d = win;
                    state_d = PKT;
                end
            end
            PKT: begin
                rdy[grant_q] = accept;
                xfer         = accept && ast.ast_valid_i[grant_q];
                if (xfer && ast.ast_endofpacket_i[grant_q]) begin
                    ptr_d   = next_dir(grant_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d = out_q;
        vld_d = vld_q;
        if (xfer) begin
            out_d.data    = ast.ast_data_i[grant_q];
            out_d.sop     = ast.ast_startofpacket_i[grant_q];
            out_d.eop     = ast.ast_endofpacket_i[grant_q];
            out_d.empty   = ast.ast_empty_i[grant_q];
            out_d.channel = ast.ast_channel_i[grant_q];
            out_d.dir     = grant_q;
            vld_d         = 1'b1;
        end else if (ast.ast_ready_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    // Readies and drop are combinational from the inputs, so mask them while held in reset.
    assign ast.ast_ready_o         = arst_n_i ? rdy : '0;
    assign ast.drop_o              = arst_n_i & drop_c;
    assign ast.ast_valid_o         = vld_q;
    assign ast.ast_data_o          = out_q.data;
    assign ast.ast_startofpacket_o = out_q.sop;
    assign ast.ast_endofpacket_o   = out_q.eop;
    assign ast.ast_empty_o         = out_q.empty;
    assign ast.ast_channel_o       = out_q.channel;
    assign ast.ast_dir_o           = out_q.dir;

endmodule

// File: tb/tb_ast_rr_mux.sv
// Bench for ast_rr_mux: per-input packet queues, packet-level round-robin model, beat scoreboard.
module tb_ast_rr_mux;
    import ast_rr_mux_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ast_rr_mux_if bus();

    ast_rr_mux dut (
        .clk_i    (clk),
        .arst_n_i (rst_n),
        .ast      (bus.slave)
    );

    int    n_assert = 0;
    int    n_fail   = 0;
    beat_t src_q [RX_DIR][$];
    int    len_q [RX_DIR][$];
    beat_t exp_q [$];
    int    m_ptr = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t cur_out();
        beat_t b;
        b.data    = bus.ast_data_o;
        b.sop     = bus.ast_startofpacket_o;
        b.eop     = bus.ast_endofpacket_o;
        b.empty   = bus.ast_empty_o;
        b.channel = bus.ast_channel_o;
        b.dir     = bus.ast_dir_o;
        return b;
    endfunction

    task automatic add_pkt(input int s, input int len, input logic [EMPTY_WIDTH-1:0] emp,
                           input logic [CHANNEL_WIDTH-1:0] ch);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data    = {$urandom, $urandom};
            b.sop     = (k == 0);
            b.eop     = (k == len - 1);
            b.empty   = b.eop ? emp : '0;
            b.channel = ch;
            b.dir     = dir_t'(s);
            src_q[s].push_back(b);
        end
        len_q[s].push_back(len);
    endtask

    // Every queued input requests at each decision, so service order is plain round robin over packets.
    task automatic plan();
        int pos [RX_DIR];
        int w, cand, len;
        for (int i = 0; i < RX_DIR; i++) pos[i] = 0;
        while (1) begin
            w = -1;
            for (int k = 0; k < RX_DIR; k++) begin
                cand = (m_ptr + k) % RX_DIR;
                if (w < 0 && len_q[cand].size() > 0) w = cand;
            end
            if (w < 0) break;
            len = len_q[w].pop_front();
            for (int k = 0; k < len; k++) exp_q.push_back(src_q[w][pos[w] + k]);
            pos[w] += len;
            m_ptr = (w + 1) % RX_DIR;
        end
    endtask

    task automatic drive_idle();
        for (int i = 0; i < RX_DIR; i++) begin
            bus.ast_data_i[i]          = '0;
            bus.ast_startofpacket_i[i] = 1'b0;
            bus.ast_endofpacket_i[i]   = 1'b0;
            bus.ast_valid_i[i]         = 1'b0;
            bus.ast_empty_i[i]         = '0;
            bus.ast_channel_i[i]       = '0;
        end
        bus.ast_ready_i = 1'b1;
    endtask

    function automatic int pending();
        int n = exp_q.size();
        for (int i = 0; i < RX_DIR; i++) n += src_q[i].size();
        return n;
    endfunction

    // mode 0: always valid/ready; 1: random valid on non-sop beats and random ready;
    // 2: ready low for cycles 4..8 of the run.
    task automatic run(input int mode, input int max_cyc, input bit partial, input bit gap_chk);
        beat_t             h, ob, prev_out, prev_in, e;
        bit                prev_stall, prev_in_v, ready_ok, acc;
        logic [RX_DIR-1:0] in_x;
        int                last_out;
        prev_stall = 1'b0;
        prev_in_v  = 1'b0;
        last_out   = -1;
        prev_out   = '0;
        prev_in    = '0;
        for (int c = 0; c < max_cyc; c++) begin
            if (!partial && pending() == 0) break;
            for (int i = 0; i < RX_DIR; i++) begin
                if (src_q[i].size() > 0) begin
                    h = src_q[i][0];
                    bus.ast_data_i[i]          = h.data;
                    bus.ast_startofpacket_i[i] = h.sop;
                    bus.ast_endofpacket_i[i]   = h.eop;
                    bus.ast_empty_i[i]         = h.empty;
                    bus.ast_channel_i[i]       = h.channel;
                    bus.ast_valid_i[i]         = h.sop || (mode != 1) || ($urandom_range(3) != 0);
                end else begin
                    bus.ast_data_i[i]          = '0;
                    bus.ast_startofpacket_i[i] = 1'b0;
                    bus.ast_endofpacket_i[i]   = 1'b0;
                    bus.ast_empty_i[i]         = '0;
                    bus.ast_channel_i[i]       = '0;
                    bus.ast_valid_i[i]         = 1'b0;
                end
            end
            case (mode)
                1:       bus.ast_ready_i = ($urandom_range(9) < 7);
                2:       bus.ast_ready_i = !(c >= 4 && c < 9);
                default: bus.ast_ready_i = 1'b1;
            endcase

            @(negedge clk);
            ob   = cur_out();
            in_x = bus.ast_valid_i & bus.ast_ready_o;
            acc  = !bus.ast_valid_o || bus.ast_ready_i;
            ready_ok = ((bus.ast_ready_o & (bus.ast_ready_o - 1'b1)) == '0) &&
                       (acc || bus.ast_ready_o == '0);
            chk("ready_rule", 128'(ready_ok), 128'(1));
            if (prev_stall) chk("hold", 128'({bus.ast_valid_o, ob}), 128'({1'b1, prev_out}));
            if (prev_in_v)  chk("latency", 128'({bus.ast_valid_o, ob}), 128'({1'b1, prev_in}));
            if (bus.ast_valid_o && bus.ast_ready_i) begin
                if (exp_q.size() == 0) chk("extra_beat", 128'(bus.ast_valid_o), 128'(0));
                else begin
                    e = exp_q.pop_front();
                    chk("beat", 128'(ob), 128'(e));
                end
                if (gap_chk && last_out >= 0) chk("gap", 128'(c - last_out), 128'(2));
                last_out = c;
            end
            prev_stall = bus.ast_valid_o && !bus.ast_ready_i;
            prev_out   = ob;
            prev_in_v  = |in_x;
            for (int i = 0; i < RX_DIR; i++) if (in_x[i]) prev_in = src_q[i][0];

            @(posedge clk);
            #1;
            for (int i = 0; i < RX_DIR; i++) if (in_x[i]) void'(src_q[i].pop_front());
        end
        if (!partial) chk("drain_timeout", 128'(pending()), 128'(0));
    endtask

    initial begin
        // Reset: readies/drop masked even with a drop candidate and a requester present.
        drive_idle();
        bus.ast_valid_i[0] = 1'b1; bus.ast_startofpacket_i[0] = 1'b1;
        bus.ast_valid_i[2] = 1'b1; bus.ast_data_i[2] = 64'h1234;
        @(negedge clk);
        chk("reset_out", 128'({bus.ast_valid_o, bus.ast_ready_o, bus.drop_o, cur_out()}), 128'(0));
        chk("reset_regs", 128'({dut.ptr_q, dut.grant_q}), 128'(0));
        drive_idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_out", 128'({bus.ast_valid_o, bus.ast_ready_o, bus.drop_o}), 128'(0));
        @(posedge clk); #1;

        // Two 3-beat packets on inputs 0 and 2 arriving together.
        add_pkt(0, 3, '0, 10'h001);
        add_pkt(2, 3, '0, 10'h002);
        plan();
        run(0, 100, 1'b0, 1'b0);
        chk("ptr_after_0_2", 128'(dut.ptr_q), 128'(3));

        // Last beat carries empty=5, channel=0x2A; pointer wraps 3 -> 0.
        add_pkt(3, 3, EMPTY_WIDTH'(5), 10'h02A);
        plan();
        run(0, 100, 1'b0, 1'b0);
        chk("ptr_wrap", 128'(dut.ptr_q), 128'(0));

        // All inputs with back-to-back single-beat packets: 8 grants, one bubble each.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < RX_DIR; i++) add_pkt(i, 1, EMPTY_WIDTH'(i), CHANNEL_WIDTH'(r * 4 + i));
        plan();
        run(0, 100, 1'b0, 1'b1);

        // Downstream stall for 5 cycles mid-packet.
        add_pkt(1, 4, EMPTY_WIDTH'(2), 10'h155);
        plan();
        run(2, 100, 1'b0, 1'b0);

        // Beat without startofpacket while IDLE is dropped.
        drive_idle();
        bus.ast_valid_i[1] = 1'b1;
        bus.ast_data_i[1]  = 64'hDEAD;
        @(negedge clk);
        chk("drop_ready", 128'(bus.ast_ready_o), 128'(4'b0010));
        chk("drop_pulse", 128'({bus.drop_o, bus.ast_valid_o}), 128'(2'b10));
        @(posedge clk); #1;
        bus.ast_valid_i[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("drop_once", 128'({bus.drop_o, bus.ast_valid_o, bus.ast_ready_o}), 128'(0));
            @(posedge clk); #1;
        end

        // Randomized traffic with random valid gaps and backpressure.
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 10; p++)
                add_pkt($urandom_range(RX_DIR - 1), $urandom_range(1, 5),
                        EMPTY_WIDTH'($urandom_range(7)), CHANNEL_WIDTH'($urandom_range(1023)));
            plan();
            run(1, 2000, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a 4-beat packet.
        add_pkt(0, 4, EMPTY_WIDTH'(1), 10'h0F0);
        plan();
        run(0, 3, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 128'({bus.ast_valid_o, bus.ast_ready_o, bus.drop_o, cur_out()}), 128'(0));
        for (int i = 0; i < RX_DIR; i++) begin
            src_q[i].delete();
            len_q[i].delete();
        end
        exp_q.delete();
        m_ptr = 0;
        drive_idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        add_pkt(3, 2, EMPTY_WIDTH'(4), 10'h033);
        plan();
        run(0, 100, 1'b0, 1'b0);
        chk("ptr_after_reset_pkt", 128'(dut.ptr_q), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ast_rr_mux.md
Name: ast_rr_mux

Overview:
Packet-level round-robin multiplexer that merges RX_DIR Avalon-ST input streams into one Avalon-ST output stream. It is the counterpart of ast_dmx, sitting on the output side of per-direction processing so that demultiplexed traffic can be re-joined. A grant is held for a whole packet, from startofpacket to endofpacket, so packets are never interleaved. The output is registered, and the output carries the source index.

Parameters:
- DATA_WIDTH, 64, data bus width in bits; must be a multiple of 8.
- EMPTY_WIDTH, $clog2(DATA_WIDTH/8), width of the empty field.
- CHANNEL_WIDTH, 10, channel field width.
- RX_DIR, 4, number of input streams; must be at least 2.
- DIR_SEL_WIDTH, (RX_DIR == 1) ? 1 : $clog2(RX_DIR), source-index width.

Ports:
- clk_i  in  1  clock; single domain.
- arst_n_i  in  1  asynchronous active-low reset.
- ast_data_i  in  [DATA_WIDTH-1:0] x RX_DIR  input data, unpacked array.
- ast_startofpacket_i  in  1 x RX_DIR  input startofpacket.
- ast_endofpacket_i  in  1 x RX_DIR  input endofpacket.
- ast_valid_i  in  1 x RX_DIR  input valid.
- ast_empty_i  in  [EMPTY_WIDTH-1:0] x RX_DIR  empty bytes; meaningful only on endofpacket.
- ast_channel_i  in  [CHANNEL_WIDTH-1:0] x RX_DIR  input channel.
- ast_ready_o  out  1 x RX_DIR  per-input ready.
- ast_data_o  out  DATA_WIDTH  output data.
- ast_startofpacket_o  out  1  output startofpacket.
- ast_endofpacket_o  out  1  output endofpacket.
- ast_valid_o  out  1  output valid.
- ast_empty_o  out  EMPTY_WIDTH  output empty.
- ast_channel_o  out  CHANNEL_WIDTH  output channel.
- ast_dir_o  out  DIR_SEL_WIDTH  index of the input the current output beat came from.
- ast_ready_i  in  1  downstream ready.
- drop_o  out  1  one-cycle pulse when a beat without startofpacket is discarded while IDLE.

Behaviour:
- Reset (arst_n_i = 0, asynchronous):
  - All outputs are 0, including ast_valid_o, every ast_ready_o and drop_o.
  - State returns to IDLE; the round-robin pointer ptr_q is 0; grant_q is 0.
  - Reset mid-packet abandons the packet; no output beat survives.
- Output register is a one-entry pipeline:
  - It loads when accept = !ast_valid_o || ast_ready_i.
  - When ast_ready_i = 1 and no new beat loads, ast_valid_o falls to 0.
  - Output fields hold steady while ast_valid_o = 1 and ast_ready_i = 0.
- Latency: an input beat accepted in cycle N appears on the output in cycle N+1.
- Input handshake: a beat transfers on input i when ast_valid_i[i] && ast_ready_o[i].
- ast_ready_o is combinational from state, grant_q and accept. At most one bit is high, except for drop-readies in IDLE.
- State IDLE:
  - Requests: req[i] = ast_valid_i[i] && ast_startofpacket_i[i].
  - Winner: the first i with req[i], searching circularly from ptr_q.
  - If any request exists: grant_q <= winner, go to PKT. No beat transfers in the IDLE cycle, giving a 1-cycle bubble per packet.
  - Any input with valid = 1 and startofpacket = 0 gets ast_ready_o[i] = 1. Its beat is discarded and drop_o pulses for one cycle; multiple simultaneous drops give a single pulse. Such inputs are not requesters.
- State PKT:
  - ast_ready_o[grant_q] = accept; all other readies are 0.
  - Each transferred beat loads the output register with its fields and ast_dir_o = grant_q.
  - On a transferred beat with endofpacket: ptr_q <= (grant_q + 1) mod RX_DIR, then go to IDLE.
  - A startofpacket seen mid-packet on the granted input is forwarded unchanged; no re-arbitration.
  - Valid deasserting mid-packet keeps the grant indefinitely.
- A single-beat packet (startofpacket and endofpacket together) follows IDLE -> PKT -> IDLE in 2 cycles.
- The pointer wraps from RX_DIR-1 to 0. When RX_DIR is not a power of two, the modulo is explicit.
- Best-case throughput: one packet of L beats per L+1 cycles.

Decomposition:
- usr_types_and_params package: DATA_WIDTH, EMPTY_WIDTH, CHANNEL_WIDTH, DIR_SEL_WIDTH, RX_DIR, and a state enum typedef (IDLE, PKT).
- Sub-module ast_rr_arbiter: combinational circular priority encoder.
  - Inputs: req[RX_DIR-1:0] and ptr.
  - Outputs: grant index and any_req.
  - Reusable by future multi-port blocks.

Test Plan:
- Inputs 0 and 2 each send a 3-beat packet starting in the same cycle, with ptr = 0.
  - Output carries input 0's packet, then input 2's packet, never interleaved.
  - ast_dir_o = 0,0,0 then 2,2,2.
  - ptr_q ends at 3.
- All 4 inputs continuously present 1-beat packets for 8 grants.
  - Grant order is 0,1,2,3,0,1,2,3; one bubble between packets.
- Granted packet with ast_ready_i held at 0 for 5 cycles mid-packet.
  - ast_valid_o stays 1 with data stable; ast_ready_o[grant] = 0; no beat is lost or duplicated.
- In IDLE, input 1 presents valid = 1, startofpacket = 0, data 0xDEAD.
  - ast_ready_o[1] = 1; drop_o pulses once; no output beat.
- Assert arst_n_i asynchronously (mid-cycle) during beat 2 of a 4-beat packet.
  - All outputs are 0 immediately; afterwards a new startofpacket on input 3 is granted normally.
- Last beat with endofpacket, empty = 5, channel = 0x2A.
  - Output shows endofpacket = 1, empty = 5, channel = 0x2A one cycle after transfer.
